// File: rtl/irq_ctl_pkg.sv
// rtl/irq_ctl_pkg.sv - register map, CTRL bit positions and VEC packing for irq_ctl
package irq_ctl_pkg;

    localparam logic [2:0] REG_PEND_L = 3'd0;
    localparam logic [2:0] REG_PEND_H = 3'd1;
    localparam logic [2:0] REG_MASK_L = 3'd2;
    localparam logic [2:0] REG_MASK_H = 3'd3;
    localparam logic [2:0] REG_MODE_L = 3'd4;
    localparam logic [2:0] REG_MODE_H = 3'd5;
    localparam logic [2:0] REG_VEC    = 3'd6;
    localparam logic [2:0] REG_CTRL   = 3'd7;

    localparam int CTRL_GEN     = 0;
    localparam int CTRL_NMI_SEL = 1;

    localparam int VEC_ANY     = 7;
    localparam int VEC_IDX_MSB = 3;
    localparam int VEC_IDX_LSB = 0;

    function automatic logic [7:0] vec_pack(input logic any, input logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        v[VEC_ANY] = any;
        v[VEC_IDX_MSB:VEC_IDX_LSB] = idx;
        return v;
    endfunction

endpackage

// File: rtl/irq_chan.sv
// rtl/irq_chan.sv - one interrupt channel: 2-flop synchroniser, edge detect, pending flop
module irq_chan
    import irq_ctl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_src,
    input  logic i_edge,
    input  logic i_clr,
    output logic o_pend
);

    logic [1:0] r_sync;
    logic       r_lvl;
    logic       r_pend;
    logic       w_rise;

    assign w_rise = r_sync[1] & ~r_lvl;

    // Stored pending only exists in edge mode; level mode holds it at 0 so a
    // switch back to edge starts clean. A new edge beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
            r_lvl  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_src};
            r_lvl  <= r_sync[1];
            if (!i_edge)
                r_pend <= 1'b0;
            else if (w_rise)
                r_pend <= 1'b1;
            else if (i_clr)
                r_pend <= 1'b0;
        end
    end

    assign o_pend = i_edge ? r_pend : r_lvl;

endmodule

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - memory-mapped interrupt controller with priority vector and IRQ/NMI routing
module irq_ctl
    import irq_ctl_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter bit NMI_DEFAULT = 1'b0
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            CS,
    input  logic [2:0]      A,
    input  logic [7:0]      DI,
    input  logic            WE,
    output logic [7:0]      DO,
    input  logic [N_CH-1:0] SRC,
    output logic            IRQ,
    output logic            NMI
);

    logic [N_CH-1:0] r_mask, r_mode;
    logic [N_CH-1:0] w_pend, w_act, w_clr, w_mask_nx, w_mode_nx, w_irq_act;
    logic            r_gen, r_nmi_sel, r_irq, r_nmi;
    logic [7:0]      r_do, w_rdata;
    logic            w_wr, w_rd, w_any;
    logic [3:0]      w_idx;
    logic [15:0]     w_pend16, w_mask16, w_mode16;

    assign w_wr  = CS & WE;
    assign w_rd  = CS & ~WE;
    assign w_act = w_pend & r_mask;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        irq_chan u_chan (
            .clk    (clk),
            .rst    (RST),
            .i_src  (SRC[g]),
            .i_edge (r_mode[g]),
            .i_clr  (w_clr[g]),
            .o_pend (w_pend[g])
        );
    end

    always_comb begin
        w_mask_nx = r_mask;
        w_mode_nx = r_mode;
        w_clr     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_wr && A == ((i < 8) ? REG_MASK_L : REG_MASK_H))
                w_mask_nx[i] = DI[i[2:0]];
            if (w_wr && A == ((i < 8) ? REG_MODE_L : REG_MODE_H))
                w_mode_nx[i] = DI[i[2:0]];
            w_clr[i] = w_wr && ((A == ((i < 8) ? REG_PEND_L : REG_PEND_H) && DI[i[2:0]]) ||
                                (A == REG_VEC && DI[3:0] == 4'(i)));
        end
    end

    // Scan downward so the lowest-numbered active channel is left in w_idx.
    always_comb begin
        w_any = 1'b0;
        w_idx = 4'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_any = 1'b1;
                w_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_irq_act = w_act;
        if (r_nmi_sel)
            w_irq_act[N_CH-1] = 1'b0;
    end

    always_comb begin
        w_pend16 = '0;
        w_mask16 = '0;
        w_mode16 = '0;
        w_pend16[N_CH-1:0] = w_pend;
        w_mask16[N_CH-1:0] = r_mask;
        w_mode16[N_CH-1:0] = r_mode;
    end

    always_comb begin
        w_rdata = 8'h00;
        case (A)
            REG_PEND_L: w_rdata = w_pend16[7:0];
            REG_PEND_H: w_rdata = w_pend16[15:8];
            REG_MASK_L: w_rdata = w_mask16[7:0];
            REG_MASK_H: w_rdata = w_mask16[15:8];
            REG_MODE_L: w_rdata = w_mode16[7:0];
            REG_MODE_H: w_rdata = w_mode16[15:8];
            REG_VEC:    w_rdata = vec_pack(w_any, w_idx);
            default:    w_rdata = {6'b0, r_nmi_sel, r_gen};
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_mask    <= '0;
            r_mode    <= '0;
            r_gen     <= 1'b0;
            r_nmi_sel <= NMI_DEFAULT;
            r_do      <= 8'h00;
            r_irq     <= 1'b0;
            r_nmi     <= 1'b0;
        end else begin
            r_mask <= w_mask_nx;
            r_mode <= w_mode_nx;
            if (w_wr && A == REG_CTRL) begin
                r_gen     <= DI[CTRL_GEN];
                r_nmi_sel <= DI[CTRL_NMI_SEL];
            end
            if (w_rd)
                r_do <= w_rdata;
            r_irq <= r_gen & (|w_irq_act);
            r_nmi <= r_gen & r_nmi_sel & w_act[N_CH-1];
        end
    end

    assign DO  = r_do;
    assign IRQ = r_irq;
    assign NMI = r_nmi;

endmodule

// File: tb/tb_irq_ctl.sv
// tb/tb_irq_ctl.sv - directed self-checking bench for irq_ctl (8- and 16-channel instances)
module tb_irq_ctl;
    import irq_ctl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs8 = 1'b0, cs16 = 1'b0, we = 1'b0;
    logic [2:0]  a = 3'd0;
    logic [7:0]  di = 8'h00;
    logic [7:0]  do8, do16;
    logic [7:0]  src8 = 8'h00;
    logic [15:0] src16 = 16'h0000;
    logic        irq8, nmi8, irq16, nmi16;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    irq_ctl #(.N_CH(8), .NMI_DEFAULT(1'b0)) dut8 (
        .clk(clk), .RST(rst), .CS(cs8), .A(a), .DI(di), .WE(we), .DO(do8),
        .SRC(src8), .IRQ(irq8), .NMI(nmi8)
    );

    irq_ctl #(.N_CH(16), .NMI_DEFAULT(1'b1)) dut16 (
        .clk(clk), .RST(rst), .CS(cs16), .A(a), .DI(di), .WE(we), .DO(do16),
        .SRC(src16), .IRQ(irq16), .NMI(nmi16)
    );

    // All tasks start and end on a falling edge.
    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input bit wide, input logic [2:0] ad, input logic [7:0] d);
        cs8 = !wide; cs16 = wide; we = 1'b1; a = ad; di = d;
        @(negedge clk);
        cs8 = 1'b0; cs16 = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input bit wide, input logic [2:0] ad, output logic [7:0] d);
        cs8 = !wide; cs16 = wide; we = 1'b0; a = ad;
        @(negedge clk);
        cs8 = 1'b0; cs16 = 1'b0;
        d = wide ? do16 : do8;
    endtask

    task automatic do_reset();
        src8 = 8'h00; src16 = 16'h0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v, exp16;
        rst = 1'b1;
        nclk(2);
        checks++; if ({irq8, nmi8, do8} !== 10'h000) $display("FAIL reset_out8: got %h want 000", {irq8, nmi8, do8}); else passed++;
        checks++; if ({irq16, nmi16, do16} !== 10'h000) $display("FAIL reset_out16: got %h want 000", {irq16, nmi16, do16}); else passed++;
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rd(1'b0, 3'(r), v);
            checks++; if (v !== 8'h00) $display("FAIL reset_reg8_%0d: got %h want 00", r, v); else passed++;
            exp16 = (r == 7) ? 8'h02 : 8'h00;
            rd(1'b1, 3'(r), v);
            checks++; if (v !== exp16) $display("FAIL reset_reg16_%0d: got %h want %h", r, v, exp16); else passed++;
        end
    endtask

    task automatic test_edge();
        logic [7:0] v;
        do_reset();
        wr(1'b0, REG_MASK_L, 8'h04);
        wr(1'b0, REG_MODE_L, 8'h04);
        wr(1'b0, REG_CTRL, 8'h01);
        src8[2] = 1'b1;
        nclk(1);
        src8[2] = 1'b0;
        checks++; if (irq8 !== 1'b0) $display("FAIL edge_irq_e0: got %b want 0", irq8); else passed++;
        nclk(2);
        checks++; if (irq8 !== 1'b0) $display("FAIL edge_irq_e2: got %b want 0", irq8); else passed++;
        nclk(1);
        checks++; if (irq8 !== 1'b1) $display("FAIL edge_irq_e3: got %b want 1", irq8); else passed++;
        rd(1'b0, REG_PEND_L, v);
        checks++; if (v !== 8'h04) $display("FAIL edge_pend: got %h want 04", v); else passed++;
        rd(1'b0, REG_VEC, v);
        checks++; if (v !== 8'h82) $display("FAIL edge_vec: got %h want 82", v); else passed++;
        wr(1'b0, REG_VEC, 8'h02);
        checks++; if (irq8 !== 1'b1) $display("FAIL edge_clr_e0: got %b want 1", irq8); else passed++;
        nclk(1);
        checks++; if (irq8 !== 1'b0) $display("FAIL edge_clr_e1: got %b want 0", irq8); else passed++;
    endtask

    task automatic test_level();
        logic [7:0] v;
        do_reset();
        wr(1'b0, REG_MASK_L, 8'h20);
        wr(1'b0, REG_CTRL, 8'h01);
        src8[5] = 1'b1;
        nclk(4);
        checks++; if (irq8 !== 1'b1) $display("FAIL level_irq_on: got %b want 1", irq8); else passed++;
        wr(1'b0, REG_PEND_L, 8'h20);
        nclk(1);
        checks++; if (irq8 !== 1'b1) $display("FAIL level_w1c_irq: got %b want 1", irq8); else passed++;
        rd(1'b0, REG_PEND_L, v);
        checks++; if (v !== 8'h20) $display("FAIL level_w1c_pend: got %h want 20", v); else passed++;
        src8[5] = 1'b0;
        nclk(3);
        checks++; if (irq8 !== 1'b1) $display("FAIL level_drop_e2: got %b want 1", irq8); else passed++;
        nclk(1);
        checks++; if (irq8 !== 1'b0) $display("FAIL level_drop_e3: got %b want 0", irq8); else passed++;
    endtask

    task automatic test_priority();
        logic [7:0] v;
        do_reset();
        wr(1'b0, REG_MASK_L, 8'h48);
        wr(1'b0, REG_MODE_L, 8'h48);
        wr(1'b0, REG_CTRL, 8'h01);
        src8 = 8'h48;
        nclk(1);
        src8 = 8'h00;
        nclk(3);
        rd(1'b0, REG_VEC, v);
        checks++; if (v !== 8'h83) $display("FAIL prio_vec_3: got %h want 83", v); else passed++;
        wr(1'b0, REG_VEC, 8'h0B);
        rd(1'b0, REG_VEC, v);
        checks++; if (v !== 8'h83) $display("FAIL prio_vec_oob: got %h want 83", v); else passed++;
        wr(1'b0, REG_VEC, 8'h03);
        rd(1'b0, REG_VEC, v);
        checks++; if (v !== 8'h86) $display("FAIL prio_vec_6: got %h want 86", v); else passed++;
        wr(1'b0, REG_PEND_L, 8'h40);
        rd(1'b0, REG_VEC, v);
        checks++; if (v !== 8'h00) $display("FAIL prio_vec_none: got %h want 00", v); else passed++;
        checks++; if (irq8 !== 1'b0) $display("FAIL prio_irq_off: got %b want 0", irq8); else passed++;
    endtask

    task automatic test_nmi();
        logic [7:0] v;
        do_reset();
        wr(1'b1, REG_MASK_H, 8'h80);
        wr(1'b1, REG_MODE_H, 8'h80);
        wr(1'b1, REG_CTRL, 8'h03);
        src16[15] = 1'b1;
        nclk(1);
        src16[15] = 1'b0;
        nclk(3);
        checks++; if ({nmi16, irq16} !== 2'b10) $display("FAIL nmi_route: got nmi/irq %b want 10", {nmi16, irq16}); else passed++;
        rd(1'b1, REG_VEC, v);
        checks++; if (v !== 8'h8F) $display("FAIL nmi_vec: got %h want 8f", v); else passed++;
        rd(1'b1, REG_PEND_H, v);
        checks++; if (v !== 8'h80) $display("FAIL nmi_pend_h: got %h want 80", v); else passed++;
        rd(1'b1, REG_PEND_L, v);
        checks++; if (v !== 8'h00) $display("FAIL nmi_pend_l: got %h want 00", v); else passed++;
        wr(1'b1, REG_CTRL, 8'h01);
        nclk(1);
        checks++; if ({nmi16, irq16} !== 2'b01) $display("FAIL nmi_unroute: got nmi/irq %b want 01", {nmi16, irq16}); else passed++;
    endtask

    task automatic test_same_cycle();
        logic [7:0] v;
        do_reset();
        wr(1'b0, REG_MASK_L, 8'h02);
        wr(1'b0, REG_MODE_L, 8'h02);
        wr(1'b0, REG_CTRL, 8'h01);
        src8[1] = 1'b1;
        nclk(2);
        wr(1'b0, REG_PEND_L, 8'h02);
        rd(1'b0, REG_PEND_L, v);
        checks++; if (v !== 8'h02) $display("FAIL same_cycle_set_wins: got %h want 02", v); else passed++;
        wr(1'b0, REG_PEND_L, 8'h02);
        nclk(4);
        rd(1'b0, REG_PEND_L, v);
        checks++; if (v !== 8'h00) $display("FAIL no_retrigger: got %h want 00", v); else passed++;
        checks++; if (irq8 !== 1'b0) $display("FAIL no_retrigger_irq: got %b want 0", irq8); else passed++;
        wr(1'b0, REG_MODE_L, 8'h00);
        rd(1'b0, REG_PEND_L, v);
        checks++; if (v !== 8'h02) $display("FAIL to_level_pend: got %h want 02", v); else passed++;
        wr(1'b0, REG_MODE_L, 8'h02);
        rd(1'b0, REG_PEND_L, v);
        checks++; if (v !== 8'h00) $display("FAIL to_edge_pend: got %h want 00", v); else passed++;
    endtask

    task automatic test_async_reset();
        logic [7:0] v;
        do_reset();
        wr(1'b0, REG_MASK_L, 8'h01);
        wr(1'b0, REG_MODE_L, 8'h01);
        wr(1'b0, REG_CTRL, 8'h01);
        src8[0] = 1'b1;
        nclk(4);
        rd(1'b0, REG_PEND_L, v);
        checks++; if (v !== 8'h01 || irq8 !== 1'b1) $display("FAIL arst_setup: got pend %h irq %b want 01 1", v, irq8); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if ({irq8, nmi8, do8} !== 10'h000) $display("FAIL arst_immediate: got %h want 000", {irq8, nmi8, do8}); else passed++;
        src8 = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rd(1'b0, 3'(r), v);
            checks++; if (v !== 8'h00) $display("FAIL arst_reg_%0d: got %h want 00", r, v); else passed++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_edge();
        test_level();
        test_priority();
        test_nmi();
        test_same_cycle();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
